// File: rtl/and_te_checker.sv
// and_te_checker
//   Response checker for the two-input trit AND unit. Each strobed sample
//   carries the operands (a, b) and the unit's response (c, err). The block
//   computes the expected response, compares it, counts passes and failures,
//   and latches the first mismatch of a run. A run covers NUM_SAMPLES
//   accepted strobes and then reports done.
//
//   Trit encoding: 2'b10 = +1, 2'b00 = 0, 2'b01 = -1, 2'b11 = invalid.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   start         one-cycle pulse, begins a run (from IDLE or DONE)
//   sample_valid  a, b, c, err valid this cycle
//   a, b          operand trits
//   c, err        response trit and error flag from the unit under check
//   busy          run in progress
//   done          run complete, held until next start or rst
//   pass_cnt      samples that matched
//   fail_cnt      samples that mismatched
//   mismatch      sticky, set on the first failure of a run
//   first_idx     0-based index of the first failing sample
//   first_a/b/c   captured operands/response of the first failure
//   first_err     captured err of the first failure
module and_te_checker #(
    parameter int unsigned NUM_SAMPLES = 16,
    parameter int unsigned CW          = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          sample_valid,
    input  logic [1:0]    a,
    input  logic [1:0]    b,
    input  logic [1:0]    c,
    input  logic          err,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] pass_cnt,
    output logic [CW-1:0] fail_cnt,
    output logic          mismatch,
    output logic [CW-1:0] first_idx,
    output logic [1:0]    first_a,
    output logic [1:0]    first_b,
    output logic [1:0]    first_c,
    output logic          first_err
);

    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_SAMPLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nx;

    logic          start_run;
    logic          accept;
    logic [CW-1:0] idx;
    logic          taken;      // last strobe of the run has been accepted

    // Stage 1: registered sample awaiting evaluation
    logic          s1_valid;
    logic [1:0]    s1_a, s1_b, s1_c;
    logic          s1_err;
    logic [CW-1:0] s1_idx;

    logic          exp_err;
    logic [1:0]    exp_c;
    logic          s1_pass;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        done      = 1'b0;
        start_run = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx  = RUN;
                    start_run = 1'b1;
                end
            end
            RUN: begin
                busy = 1'b1;
                // Leave one cycle after stage 1 has evaluated the last strobe,
                // i.e. once it is taken and the pipeline has drained.
                if (taken && !s1_valid) state_nx = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_nx  = RUN;
                    start_run = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign accept = (state == RUN) && sample_valid && !taken;

    // ---------------- expected response ----------------
    // For valid trits min() in order -1 < 0 < +1 reduces to priority:
    // any -1 gives -1, else any 0 gives 0, else +1.
    always_comb begin
        exp_err = (s1_a == 2'b11) || (s1_b == 2'b11);
        exp_c   = 2'b10;
        if (exp_err)                                exp_c = 2'b00;
        else if ((s1_a == 2'b01) || (s1_b == 2'b01)) exp_c = 2'b01;
        else if ((s1_a == 2'b00) || (s1_b == 2'b00)) exp_c = 2'b00;
    end

    assign s1_pass = (s1_err == exp_err) && (exp_err || (s1_c == exp_c));

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst || start_run) begin
            idx       <= '0;
            taken     <= 1'b0;
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_c      <= '0;
            s1_err    <= 1'b0;
            s1_idx    <= '0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            mismatch  <= 1'b0;
            first_idx <= '0;
            first_a   <= '0;
            first_b   <= '0;
            first_c   <= '0;
            first_err <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_a   <= a;
                s1_b   <= b;
                s1_c   <= c;
                s1_err <= err;
                s1_idx <= idx;
                idx    <= idx + CW'(1);
                if (idx == LAST_IDX) taken <= 1'b1;
            end
            if (s1_valid) begin
                if (s1_pass) begin
                    pass_cnt <= pass_cnt + CW'(1);
                end else begin
                    fail_cnt <= fail_cnt + CW'(1);
                    if (!mismatch) begin
                        mismatch  <= 1'b1;
                        first_idx <= s1_idx;
                        first_a   <= s1_a;
                        first_b   <= s1_b;
                        first_c   <= s1_c;
                        first_err <= s1_err;
                    end
                end
            end
        end
    end

endmodule

// File: doc/and_te_checker.md
Name: and_te_checker

Overview:
- Synthesizable response checker for the two-input trit AND unit; sits on the output side of that unit in hardware self-test and in regression benches.
- Each strobed sample carries operands a, b and the unit's response c, err. The block computes the expected response, compares, counts passes and failures, and latches the first mismatch.
- A run covers NUM_SAMPLES strobes, then the block reports done.
- Trit encoding: 2'b10 = +1, 2'b00 = 0, 2'b01 = -1, 2'b11 = invalid.

Parameters:
- NUM_SAMPLES, 16, strobes per run; legal range 1 to 2**CW-1.
- CW, 8, width of sample index and counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse; begins a run.
- sample_valid  in  1  a, b, c, err are valid this cycle.
- a  in  2  operand trit A.
- b  in  2  operand trit B.
- c  in  2  response trit from the unit under check.
- err  in  1  response error flag from the unit under check.
- busy  out  1  run in progress.
- done  out  1  run complete; held until next start or rst.
- pass_cnt  out  CW  samples that matched.
- fail_cnt  out  CW  samples that mismatched.
- mismatch  out  1  sticky; set on the first failure of a run.
- first_idx  out  CW  sample index (0-based) of the first failure.
- first_a, first_b, first_c  out  2 each  captured a, b, c of the first failure.
- first_err  out  1  captured err of the first failure.

Behaviour:
- Reset, and idle after reset: every output is 0; FSM is in IDLE; the internal sample index is 0.
- Expected response, combinational on the registered sample:
  - If a==2'b11 or b==2'b11: exp_err=1, exp_c=2'b00.
  - Otherwise: exp_err=0, exp_c=min(a,b) in trit order -1 < 0 < +1.
- Pass condition:
  - Sample passes iff err==exp_err, and also c==exp_c when exp_err==0.
  - c is don't-care when exp_err=1.
- FSM states:
  - IDLE: start moves to RUN; clears counters, mismatch, first_* and the index; sets busy=1 and done=0 on the next edge.
  - RUN: each sample_valid registers {a,b,c,err} and the index into stage 1.
    - The next cycle, stage 1 updates pass_cnt or fail_cnt by +1.
    - On a fail with mismatch==0, stage 1 also captures first_* and first_idx and sets mismatch.
    - The index increments per accepted strobe.
    - When the strobe with index NUM_SAMPLES-1 is accepted, further strobes are ignored.
    - Once stage 1 has evaluated that strobe, the FSM goes to DONE.
  - DONE: busy=0, done=1; counters frozen. start behaves as in IDLE (restart).
- Latency: counters reflect a strobe 1 cycle after it; done rises 2 cycles after the last strobe's edge.
- sample_valid outside RUN is ignored.
- start during RUN is ignored.
- start and sample_valid in the same cycle from IDLE or DONE: start is taken, the sample is dropped.
- Counters never wrap: NUM_SAMPLES < 2**CW guarantees this.
- Invariant in DONE: pass_cnt+fail_cnt == NUM_SAMPLES.
- rst mid-run: returns to IDLE and clears all outputs on that edge; the in-flight stage-1 sample is discarded.
- Back-to-back strobes every cycle are supported; throughput is 1 sample per clock.

Test Plan:
- Reset then idle, 5 cycles, no start -> all outputs 0; busy=0, done=0.
- NUM_SAMPLES=9; the 9 valid (a,b) pairs, each with the correct c and err=0, strobed back-to-back (e.g. a=10,b=01,c=01; a=00,b=10,c=00) -> done 2 cycles after last strobe; pass_cnt=9, fail_cnt=0, mismatch=0.
- NUM_SAMPLES=4; strobes (10,10,10,0), (10,00,10,0), (01,00,01,0), (11,10,00,1) -> sample 1 expects 00; sample 2 expects 01 and passes.
  - Result: pass_cnt=3, fail_cnt=1, first_idx=1, first_a=10, first_b=00, first_c=10, first_err=0.
- Error handling: a=11, b=01, c=10, err=1 -> pass (c don't-care); same operands with err=0 -> fail.
- Reset mid-run after 2 strobes, then start and run 4 good samples with gaps in sample_valid -> pass_cnt=4, fail_cnt=0, no residue from the aborted run.
- start pulsed during RUN, plus extra strobes after the last sample -> both ignored; counts unchanged; restart from DONE clears the counters.
